// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues FP requests to the FPU only when the result slot is free and returns the request tag with each result.
// Opcodes: ADD=0 SUB=1 MUL=2 DIV=3 SQRT=4 I2F=5 F2I=6 FMADD=7 FMSUB=8 FNMADD=9 FNMSUB=10; anything else is illegal.
module fpu_issue_ctrl #(
  parameter int TAG_W = 5,
  parameter int LAT_FPU = 2,
  parameter int LAT_FMA = 3,
  localparam int C_FPU01_CMD = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [C_FPU01_CMD-1:0] req_op_i,
  input  logic [TAG_W-1:0]       req_tag_i,
  output logic                   fpu_en_o,
  output logic [C_FPU01_CMD-1:0] fpu_op_o,
  input  logic                   fpu_valid_i,
  output logic                   res_valid_o,
  output logic [TAG_W-1:0]       res_tag_o,
  output logic                   res_illegal_o,
  output logic                   idle_o,
  output logic                   err_o
);
  localparam int MAXL = (LAT_FPU > LAT_FMA) ? LAT_FPU : LAT_FMA;
  localparam logic [MAXL:1] OH_FPU = MAXL'(1) << (LAT_FPU - 1);
  localparam logic [MAXL:1] OH_FMA = MAXL'(1) << (LAT_FMA - 1);
  localparam logic [C_FPU01_CMD-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
    OP_SQRT = 4'd4, OP_I2F = 4'd5, OP_F2I = 4'd6, OP_FMADD = 4'd7, OP_FMSUB = 4'd8,
    OP_FNMADD = 4'd9, OP_FNMSUB = 4'd10;
  // pend_q[k]: a result is due k-1 cycles from now, so pend_q[1] is the result due this cycle
  logic [MAXL:1] pend_q, pend_d, ill_q, ill_d, slot, post;
  logic [MAXL:1][TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] ds_tag_q, ds_tag_d;
  logic ds_busy_q, ds_busy_d, err_q, err_d;
  logic is_pipe, is_fma, is_ds, is_ill, hs, due, exp_v, ds_done;
  always_comb begin
    is_pipe = req_op_i inside {OP_ADD, OP_SUB, OP_MUL, OP_I2F, OP_F2I};
    is_fma = req_op_i inside {OP_FMADD, OP_FMSUB, OP_FNMADD, OP_FNMSUB};
    is_ds = req_op_i inside {OP_DIV, OP_SQRT};
    is_ill = ~(is_pipe | is_fma | is_ds);
    slot = is_pipe ? OH_FPU : is_fma ? OH_FMA : MAXL'(1);
    post = pend_q >> 1;
    req_ready_o = ~ds_busy_q & (is_ds ? ~|post : ~|(post & slot));
    hs = req_valid_i & req_ready_o;
    fpu_en_o = hs & ~is_ill;
    fpu_op_o = req_op_i;
    due = pend_q[1];
    exp_v = due & ~ill_q[1];
    ds_done = ds_busy_q & fpu_valid_i & ~due;
    res_valid_o = due | ds_done;
    res_tag_o = due ? tag_q[1] : ds_tag_q;
    res_illegal_o = due & ill_q[1];
    idle_o = ~ds_busy_q & ~|pend_q;
    pend_d = post | ((hs & ~is_ds) ? slot : '0);
    ill_d = (ill_q >> 1) | ((hs & is_ill) ? slot : '0);
    tag_d = tag_q >> TAG_W;
    for (int k = 1; k <= MAXL; k++)
      if (hs & ~is_ds & slot[k]) tag_d[k] = req_tag_i;
    ds_busy_d = (hs & is_ds) | (ds_busy_q & ~ds_done);
    ds_tag_d = (hs & is_ds) ? req_tag_i : ds_tag_q;
    err_d = err_q | (exp_v & ~fpu_valid_i) | (fpu_valid_i & ~exp_v & ~ds_busy_q);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      ill_q <= '0;
      tag_q <= '0;
      ds_tag_q <= '0;
      ds_busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ill_q <= ill_d;
      tag_q <= tag_d;
      ds_tag_q <= ds_tag_d;
      ds_busy_q <= ds_busy_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scenarios plus random traffic checked against a due-cycle scoreboard model.
module tb_fpu_issue_ctrl;
  localparam int LF = 2, LM = 3;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, fpu_en, fv, res_valid, res_illegal, idle, err;
  logic [3:0] req_op, fpu_op;
  logic [4:0] req_tag, res_tag;
  always #5 clk = ~clk;

  fpu_issue_ctrl #(.TAG_W(5), .LAT_FPU(LF), .LAT_FMA(LM)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_tag_i(req_tag), .fpu_en_o(fpu_en), .fpu_op_o(fpu_op),
    .fpu_valid_i(fv), .res_valid_o(res_valid), .res_tag_o(res_tag),
    .res_illegal_o(res_illegal), .idle_o(idle), .err_o(err));

  typedef struct {int due; logic [4:0] tag; bit ill;} ent_t;
  ent_t q[$];
  bit ds_out, m_err, last_hs;
  logic [4:0] ds_tag;
  int now, checks, failures;

  // class: 0 pipelined, 1 fused multiply-add, 2 div/sqrt, 3 illegal
  function automatic int cls_of(logic [3:0] op);
    if (op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6}) return 0;
    if (op inside {4'd7, 4'd8, 4'd9, 4'd10}) return 1;
    if (op inside {4'd3, 4'd4}) return 2;
    return 3;
  endfunction

  function automatic int lat_of(int c);
    return c == 0 ? LF : c == 1 ? LM : 1;
  endfunction

  function automatic int due_idx(int t);
    foreach (q[i]) if (q[i].due == t) return i;
    return -1;
  endfunction

  function automatic bit later_pending();
    foreach (q[i]) if (q[i].due > now) return 1;
    return 0;
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", name, obs, exp, now);
    end
  endtask

  // bench plays the FPU: returns results exactly when due, finishes div/sqrt at a random time
  task automatic drive(bit v, logic [3:0] op, logic [4:0] tag);
    int di;
    req_valid = v; req_op = op; req_tag = tag;
    di = due_idx(now);
    if (di >= 0) fv = !q[di].ill;
    else fv = ds_out && ($urandom_range(0, 3) == 0);
  endtask

  task automatic cyc();
    int di, c;
    bit found, hs, rdy, rv;
    @(negedge clk);
    if (rst) begin
      q.delete(); ds_out = 0; m_err = 0; last_hs = 0;
    end else begin
      di = due_idx(now);
      found = di >= 0;
      c = cls_of(req_op);
      rdy = !ds_out && (c == 2 ? !later_pending() : due_idx(now + lat_of(c)) < 0);
      hs = req_valid && rdy;
      rv = found || (ds_out && fv);
      chk("ready", 32'(req_ready), 32'(rdy));
      chk("fpu_en", 32'(fpu_en), 32'(hs && c != 3));
      chk("fpu_op", 32'(fpu_op), 32'(req_op));
      chk("res_valid", 32'(res_valid), 32'(rv));
      if (rv) chk("res_tag", 32'(res_tag), 32'(found ? q[di].tag : ds_tag));
      chk("res_illegal", 32'(res_illegal), 32'(found && q[di].ill));
      chk("idle", 32'(idle), 32'(!ds_out && q.size() == 0));
      chk("err", 32'(err), 32'(m_err));
      if (found ? (!q[di].ill && !fv) : (fv && !ds_out)) m_err = 1;
      if (found && q[di].ill && fv && !ds_out) m_err = 1;
      if (!found && ds_out && fv) ds_out = 0;
      if (found) q.delete(di);
      if (hs && c == 2) begin ds_out = 1; ds_tag = req_tag; end
      else if (hs) q.push_back('{now + lat_of(c), req_tag, c == 3});
      last_hs = hs;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic idle_cycles(int n);
    repeat (n) begin drive(0, 4'd0, 5'd0); cyc(); end
  endtask

  task automatic issue(logic [3:0] op, logic [4:0] tag, output int waited);
    int n = 0;
    do begin drive(1, op, tag); cyc(); n++; end while (!last_hs && n < 60);
    chk("issue_bound", 32'(last_hs), 32'd1);
    waited = n - 1;
  endtask

  task automatic reset_dut();
    rst = 1; drive(0, 4'd0, 5'd0); fv = 0;
    cyc(); cyc();
    rst = 0;
  endtask

  initial begin
    int w;
    rst = 1; req_valid = 0; req_op = 0; req_tag = 0; fv = 0;
    checks = 0; failures = 0; now = 0;
    reset_dut();
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    // ADD tag 3, result two cycles later
    issue(4'd0, 5'd3, w);
    chk("t1_no_wait", 32'(w), 32'd0);
    drive(0, 4'd0, 5'd0); cyc();
    drive(0, 4'd0, 5'd0);
    #1 chk("t1_res_tag", 32'(res_tag), 32'd3);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    cyc();
    idle_cycles(3);
    // FMA then ADD colliding on expiry slot: ADD must wait one cycle
    issue(4'd7, 5'd1, w);
    issue(4'd0, 5'd2, w);
    chk("t2_add_wait", 32'(w), 32'd1);
    idle_cycles(5);
    // MUL then DIV: DIV waits for pending results, ADD waits for DIV
    issue(4'd2, 5'd4, w);
    issue(4'd3, 5'd7, w);
    chk("t3_div_wait", 32'(w), 32'd1);
    issue(4'd0, 5'd5, w);
    idle_cycles(4);
    // illegal opcode
    issue(4'd13, 5'd9, w);
    chk("t4_en_low", 32'(fpu_en), 32'd0);
    drive(0, 4'd0, 5'd0);
    #1 chk("t4_illegal", 32'(res_illegal), 32'd1);
    chk("t4_tag", 32'(res_tag), 32'd9);
    cyc();
    idle_cycles(2);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), 5'($urandom));
      cyc();
    end
    idle_cycles(4);
    while (ds_out && now < 5000) idle_cycles(1);
    // spurious FPU valid while idle
    drive(0, 4'd0, 5'd0); fv = 1; cyc();
    chk("t5_err_set", 32'(err), 32'd1);
    idle_cycles(5);
    chk("t5_err_sticky", 32'(err), 32'd1);
    reset_dut();
    chk("t5_err_cleared", 32'(err), 32'd0);
    // reset with FMA outstanding, then with DIV outstanding
    issue(4'd8, 5'd11, w);
    reset_dut();
    drive(1, 4'd0, 5'd6);
    #1 chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_idle", 32'(idle), 32'd1);
    req_valid = 0;
    issue(4'd4, 5'd12, w);
    reset_dut();
    repeat (4) begin
      drive(0, 4'd0, 5'd0); fv = 0; cyc();
    end
    chk("t6_no_stale", 32'(res_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
